decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 91 +++++++++
 rtl/decode_comb.sv | 186 ++++++++++++++++++
 rtl/decode_stage.sv | 148 ++++++++++++++
 tb/tb_decode_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode encodings: opcodes, funct fields, control enums,
// the decoded control bundle and the skid-buffer state type.
package decode_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
        ALU_LT  = 4'd3, ALU_LTU = 4'd4, ALU_XOR = 4'd5,
        ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR  = 4'd8,
        ALU_AND = 4'd9, ALU_MUL = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        MM_WR_N = 2'd0, MM_WR_B = 2'd1, MM_WR_HW = 2'd2, MM_WR_W = 2'd3
    } mm_wr_e;

    typedef enum logic [1:0] {
        DIN_SRC_ALU = 2'd0, DIN_SRC_MEM = 2'd1,
        DIN_SRC_IMM = 2'd2, DIN_SRC_PC4 = 2'd3
    } din_sel_e;

    typedef enum logic [1:0] {
        OP1_RD1 = 2'd0, OP1_PC = 2'd1, OP1_ZERO = 2'd2
    } op1_sel_e;

    typedef enum logic [1:0] {
        OP2_RD2 = 2'd0, OP2_IMM = 2'd1
    } op2_sel_e;

    typedef enum logic [1:0] {
        PC_SEL_PC4 = 2'd0, PC_SEL_BR = 2'd1,
        PC_SEL_JAL = 2'd2, PC_SEL_JALR = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SKID = 2'd2
    } state_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        alu_op_e    alu_ctl;
        op1_sel_e   op1_sel;
        op2_sel_e   op2_sel;
        din_sel_e   din_sel;
        pc_sel_e    pc_sel;
        mm_wr_e     mm_wr;
        logic [2:0] trim_ctl;
        logic       reg_wr;
        logic       illegal;
    } ctl_t;

    function automatic alu_op_e alu_base(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_LT;
            F3_SLTU: op = ALU_LTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I decoder: instr -> control bundle + immediate.
// Ports: instr (raw 32b), ctl (decoded controls), imm (sign-extended).
module decode_comb
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int EN_M = 0
) (
    input  logic [31:0]     instr,
    output ctl_t            ctl,
    output logic [XLEN-1:0] imm
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1_f, rs2_f, rd_f;

    assign opc   = instr[6:0];
    assign rd_f  = instr[11:7];
    assign f3    = instr[14:12];
    assign rs1_f = instr[19:15];
    assign rs2_f = instr[24:20];
    assign f7    = instr[31:25];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    logic       use_rs1, use_rs2, use_rd;
    logic       wr, ill, bad_idx, ill_all;
    logic [2:0] trim;
    alu_op_e    alu;
    op1_sel_e   op1;
    op2_sel_e   op2;
    din_sel_e   din;
    pc_sel_e    pcs;
    mm_wr_e     mm;

    always_comb begin
        imm32   = 32'd0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        wr      = 1'b0;
        ill     = 1'b0;
        trim    = 3'd0;
        alu     = ALU_ADD;
        op1     = OP1_RD1;
        op2     = OP2_RD2;
        din     = DIN_SRC_ALU;
        pcs     = PC_SEL_PC4;
        mm      = MM_WR_N;
        unique case (1'b1)
            (opc == OPC_OP): begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                wr      = 1'b1;
                unique case (f7)
                    F7_BASE: alu = alu_base(f3);
                    F7_ALT: begin
                        if (f3 == F3_ADD)     alu = ALU_SUB;
                        else if (f3 == F3_SR) alu = ALU_SRA;
                        else                  ill = 1'b1;
                    end
                    F7_MUL: begin
                        if (EN_M != 0 && f3 == F3_ADD) alu = ALU_MUL;
                        else                           ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            (opc == OPC_OP_IMM): begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                wr      = 1'b1;
                imm32   = imm_i;
                op2     = OP2_IMM;
                // shift-right flavour lives in instr[30] for immediates
                alu = (f3 == F3_SR && instr[30]) ? ALU_SRA : alu_base(f3);
            end
            (opc == OPC_LOAD): begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                wr      = 1'b1;
                imm32   = imm_i;
                op2     = OP2_IMM;
                din     = DIN_SRC_MEM;
                trim    = f3;
                ill     = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            (opc == OPC_STORE): begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = imm_s;
                op2     = OP2_IMM;
                ill     = (f3 > 3'b010);
                unique case (f3)
                    3'b000:  mm = MM_WR_B;
                    3'b001:  mm = MM_WR_HW;
                    3'b010:  mm = MM_WR_W;
                    default: mm = MM_WR_N;
                endcase
            end
            (opc == OPC_LUI): begin
                use_rd = 1'b1;
                wr     = 1'b1;
                imm32  = imm_u;
                op1    = OP1_ZERO;
                op2    = OP2_IMM;
                din    = DIN_SRC_IMM;
            end
            (opc == OPC_AUIPC): begin
                use_rd = 1'b1;
                wr     = 1'b1;
                imm32  = imm_u;
                op1    = OP1_PC;
                op2    = OP2_IMM;
            end
            (opc == OPC_JAL): begin
                use_rd = 1'b1;
                wr     = 1'b1;
                imm32  = imm_j;
                op1    = OP1_PC;
                op2    = OP2_IMM;
                din    = DIN_SRC_PC4;
                pcs    = PC_SEL_JAL;
            end
            (opc == OPC_JALR): begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                wr      = 1'b1;
                imm32   = imm_i;
                op2     = OP2_IMM;
                din     = DIN_SRC_PC4;
                pcs     = PC_SEL_JALR;
            end
            (opc == OPC_BRANCH): begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = imm_b;
                pcs     = PC_SEL_BR;
                // execute needs the condition code to resolve the branch
                trim    = f3;
                unique case (f3[2:1])
                    2'b00:   alu = ALU_SUB;
                    2'b10:   alu = ALU_LT;
                    default: alu = ALU_LTU;
                endcase
            end
            default: ill = 1'b1;
        endcase
    end

    assign bad_idx = (use_rs1 && int'(rs1_f) >= NREG)
                  || (use_rs2 && int'(rs2_f) >= NREG)
                  || (use_rd  && int'(rd_f)  >= NREG);
    assign ill_all = ill || bad_idx;

    always_comb begin
        ctl          = '0;
        ctl.rs1      = use_rs1 ? rs1_f : 5'd0;
        ctl.rs2      = use_rs2 ? rs2_f : 5'd0;
        ctl.rd       = use_rd  ? rd_f  : 5'd0;
        ctl.alu_ctl  = alu;
        ctl.op1_sel  = op1;
        ctl.op2_sel  = op2;
        ctl.din_sel  = din;
        ctl.pc_sel   = pcs;
        ctl.mm_wr    = ill_all ? MM_WR_N : mm;
        ctl.trim_ctl = trim;
        ctl.reg_wr   = wr && !ill_all && (rd_f != 5'd0);
        ctl.illegal  = ill_all;
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decode_comb plus a two-entry skid buffer.
// Ports: fetch side IN_* (valid/ready), execute side OUT_* and bundle.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int EN_M = 0,
    parameter int SKID = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     IN_INSTR,
    input  logic [XLEN-1:0] IN_PC,
    input  logic            FLUSH,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] OUT_PC,
    output logic [4:0]      RS1,
    output logic [4:0]      RS2,
    output logic [4:0]      RD,
    output logic [XLEN-1:0] IMM,
    output logic [3:0]      ALU_CTL,
    output logic [1:0]      OP1_SEL,
    output logic [1:0]      OP2_SEL,
    output logic [1:0]      DIN_SEL,
    output logic [1:0]      PC_SEL,
    output logic [1:0]      MM_WR,
    output logic [2:0]      TRIM_CTL,
    output logic            REG_WR,
    output logic            ILLEGAL
);

    ctl_t            dec_ctl;
    logic [XLEN-1:0] dec_imm;

    decode_comb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .EN_M (EN_M)
    ) u_dec (
        .instr (IN_INSTR),
        .ctl   (dec_ctl),
        .imm   (dec_imm)
    );

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    ctl_t            head_ctl, head_ctl_d, skid_ctl, skid_ctl_d;
    logic [XLEN-1:0] head_pc, head_pc_d, skid_pc, skid_pc_d;
    logic [XLEN-1:0] head_imm, head_imm_d, skid_imm, skid_imm_d;
    logic            accept, consume;

    assign OUT_VALID = (state_q != ST_EMPTY);
    // without a skid entry, readiness must follow the consumer directly
    assign IN_READY  = (SKID != 0) ? in_ready_q
                                   : (state_q == ST_EMPTY) || OUT_READY;
    assign accept    = IN_VALID && IN_READY;
    assign consume   = OUT_VALID && OUT_READY;

    always_comb begin
        state_d    = state_q;
        head_ctl_d = head_ctl;
        head_pc_d  = head_pc;
        head_imm_d = head_imm;
        skid_ctl_d = skid_ctl;
        skid_pc_d  = skid_pc;
        skid_imm_d = skid_imm;
        if (FLUSH) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d    = ST_FULL;
                        head_ctl_d = dec_ctl;
                        head_pc_d  = IN_PC;
                        head_imm_d = dec_imm;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        head_ctl_d = dec_ctl;
                        head_pc_d  = IN_PC;
                        head_imm_d = dec_imm;
                    end else if (accept) begin
                        state_d    = ST_SKID;
                        skid_ctl_d = dec_ctl;
                        skid_pc_d  = IN_PC;
                        skid_imm_d = dec_imm;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (consume) begin
                        state_d    = ST_FULL;
                        head_ctl_d = skid_ctl;
                        head_pc_d  = skid_pc;
                        head_imm_d = skid_imm;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            head_ctl   <= '0;
            head_pc    <= '0;
            head_imm   <= '0;
            skid_ctl   <= '0;
            skid_pc    <= '0;
            skid_imm   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_ctl   <= head_ctl_d;
            head_pc    <= head_pc_d;
            head_imm   <= head_imm_d;
            skid_ctl   <= skid_ctl_d;
            skid_pc    <= skid_pc_d;
            skid_imm   <= skid_imm_d;
        end
    end

    assign OUT_PC   = head_pc;
    assign IMM      = head_imm;
    assign RS1      = head_ctl.rs1;
    assign RS2      = head_ctl.rs2;
    assign RD       = head_ctl.rd;
    assign ALU_CTL  = head_ctl.alu_ctl;
    assign OP1_SEL  = head_ctl.op1_sel;
    assign OP2_SEL  = head_ctl.op2_sel;
    assign DIN_SEL  = head_ctl.din_sel;
    assign PC_SEL   = head_ctl.pc_sel;
    assign MM_WR    = head_ctl.mm_wr;
    assign TRIM_CTL = head_ctl.trim_ctl;
    assign REG_WR   = head_ctl.reg_wr;
    assign ILLEGAL  = head_ctl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, skid ordering,
// flush, reset, and an RV32E (NREG=16) instance for index checks.
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID, IN_READY, FLUSH, OUT_VALID, OUT_READY;
    logic [31:0] IN_INSTR, IN_PC, OUT_PC, IMM;
    logic [4:0]  RS1, RS2, RD;
    logic [3:0]  ALU_CTL;
    logic [1:0]  OP1_SEL, OP2_SEL, DIN_SEL, PC_SEL, MM_WR;
    logic [2:0]  TRIM_CTL;
    logic        REG_WR, ILLEGAL;

    logic        e_valid, e_in_ready, e_out_valid;
    logic [31:0] e_out_pc, e_imm;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [3:0]  e_alu;
    logic [1:0]  e_op1, e_op2, e_din, e_pcs, e_mm;
    logic [2:0]  e_trim;
    logic        e_reg_wr, e_ill;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    decode_stage u_dut (
        .CLK (CLK), .RST (RST),
        .IN_VALID (IN_VALID), .IN_READY (IN_READY),
        .IN_INSTR (IN_INSTR), .IN_PC (IN_PC),
        .FLUSH (FLUSH),
        .OUT_VALID (OUT_VALID), .OUT_READY (OUT_READY),
        .OUT_PC (OUT_PC),
        .RS1 (RS1), .RS2 (RS2), .RD (RD), .IMM (IMM),
        .ALU_CTL (ALU_CTL),
        .OP1_SEL (OP1_SEL), .OP2_SEL (OP2_SEL),
        .DIN_SEL (DIN_SEL), .PC_SEL (PC_SEL), .MM_WR (MM_WR),
        .TRIM_CTL (TRIM_CTL), .REG_WR (REG_WR), .ILLEGAL (ILLEGAL)
    );

    decode_stage #(.NREG(16)) u_dut_e (
        .CLK (CLK), .RST (RST),
        .IN_VALID (e_valid), .IN_READY (e_in_ready),
        .IN_INSTR (IN_INSTR), .IN_PC (IN_PC),
        .FLUSH (1'b0),
        .OUT_VALID (e_out_valid), .OUT_READY (1'b1),
        .OUT_PC (e_out_pc),
        .RS1 (e_rs1), .RS2 (e_rs2), .RD (e_rd), .IMM (e_imm),
        .ALU_CTL (e_alu),
        .OP1_SEL (e_op1), .OP2_SEL (e_op2),
        .DIN_SEL (e_din), .PC_SEL (e_pcs), .MM_WR (e_mm),
        .TRIM_CTL (e_trim), .REG_WR (e_reg_wr), .ILLEGAL (e_ill)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins,
                         input logic [31:0] pc);
        IN_VALID = v;
        IN_INSTR = ins;
        IN_PC    = pc;
    endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0; OUT_READY = 1'b0; e_valid = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        tick(); tick();

        // reset state
        chk("rst_ov",  OUT_VALID, 0);
        chk("rst_ir",  IN_READY,  1);
        chk("rst_alu", ALU_CTL,   0);
        chk("rst_mm",  MM_WR,     0);
        chk("rst_wr",  REG_WR,    0);
        chk("rst_ill", ILLEGAL,   0);
        chk("rst_imm", IMM,       0);

        // addi x1,x0,5
        RST = 1'b0; OUT_READY = 1'b1;
        offer(1'b1, 32'h00500093, 32'h100);
        tick();
        chk("addi_ov",  OUT_VALID, 1);
        chk("addi_rd",  RD,        1);
        chk("addi_imm", IMM,       5);
        chk("addi_alu", ALU_CTL,   0);
        chk("addi_op2", OP2_SEL,   1);
        chk("addi_wr",  REG_WR,    1);
        chk("addi_pc",  OUT_PC,    32'h100);

        // sub x3,x1,x2 back-to-back: no bubble
        offer(1'b1, 32'h402081B3, 32'h104);
        tick();
        chk("sub_ov",  OUT_VALID, 1);
        chk("sub_pc",  OUT_PC,    32'h104);
        chk("sub_alu", ALU_CTL,   1);
        chk("sub_rs1", RS1,       1);
        chk("sub_rs2", RS2,       2);
        chk("sub_rd",  RD,        3);
        chk("sub_op2", OP2_SEL,   0);
        chk("sub_din", DIN_SEL,   0);

        offer(1'b0, 32'h0, 32'h0);
        tick();
        chk("drain_ov", OUT_VALID, 0);

        // lw then sw with execute stalled: skid ordering
        OUT_READY = 1'b0;
        offer(1'b1, 32'h00812283, 32'h200);
        tick();
        chk("lw_ir", IN_READY, 1);
        offer(1'b1, 32'h00512623, 32'h204);
        tick();
        chk("skid_ir",  IN_READY,  0);
        chk("skid_ov",  OUT_VALID, 1);
        chk("lw_pc",    OUT_PC,    32'h200);
        chk("lw_trim",  TRIM_CTL,  3'b010);
        chk("lw_din",   DIN_SEL,   1);
        chk("lw_imm",   IMM,       8);
        chk("lw_rd",    RD,        5);
        chk("lw_wr",    REG_WR,    1);
        offer(1'b0, 32'h0, 32'h0);
        tick();
        chk("skid_hold_pc", OUT_PC, 32'h200);
        OUT_READY = 1'b1;
        tick();
        chk("sw_ov",  OUT_VALID, 1);
        chk("sw_ir",  IN_READY,  1);
        chk("sw_pc",  OUT_PC,    32'h204);
        chk("sw_mm",  MM_WR,     3);
        chk("sw_imm", IMM,       12);
        chk("sw_wr",  REG_WR,    0);
        tick();
        chk("sw_once", OUT_VALID, 0);

        // flush from SKID with a new offer
        OUT_READY = 1'b0;
        offer(1'b1, 32'h00500093, 32'h300);
        tick();
        offer(1'b1, 32'h402081B3, 32'h304);
        tick();
        chk("fl_skid_ir", IN_READY, 0);
        FLUSH = 1'b1;
        offer(1'b1, 32'h00100113, 32'h308);
        tick();
        FLUSH = 1'b0;
        chk("fl_ov", OUT_VALID, 0);
        chk("fl_ir", IN_READY,  1);
        offer(1'b0, 32'h0, 32'h0);
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_quiet", OUT_VALID, 0);
        end

        // flush in FULL beats a same-cycle accept
        offer(1'b1, 32'h00500093, 32'h320);
        tick();
        chk("flf_ov0", OUT_VALID, 1);
        FLUSH = 1'b1;
        offer(1'b1, 32'h00100113, 32'h324);
        tick();
        FLUSH = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        chk("flf_ov1", OUT_VALID, 0);
        tick();
        chk("flf_ov2", OUT_VALID, 0);

        // more decode vectors, streaming
        offer(1'b1, 32'h022081B3, 32'h500);
        tick();
        chk("mul_ill", ILLEGAL, 1);
        chk("mul_wr",  REG_WR,  0);
        offer(1'b1, 32'h008000EF, 32'h504);
        tick();
        chk("jal_pcs", PC_SEL,  2);
        chk("jal_din", DIN_SEL, 3);
        chk("jal_imm", IMM,     8);
        chk("jal_wr",  REG_WR,  1);
        offer(1'b1, 32'h12345037, 32'h508);
        tick();
        chk("lui_imm", IMM,     32'h12345000);
        chk("lui_op1", OP1_SEL, 2);
        chk("lui_wr0", REG_WR,  0);
        offer(1'b1, 32'hFE208EE3, 32'h50C);
        tick();
        chk("beq_imm", IMM,     32'hFFFFFFFC);
        chk("beq_pcs", PC_SEL,  1);
        chk("beq_alu", ALU_CTL, 1);
        chk("beq_wr",  REG_WR,  0);
        offer(1'b1, 32'h0000B283, 32'h510);
        tick();
        chk("ld_ill", ILLEGAL, 1);
        offer(1'b1, 32'h0000007F, 32'h514);
        tick();
        chk("opc_ill", ILLEGAL, 1);
        chk("opc_mm",  MM_WR,   0);

        // reset from FULL
        OUT_READY = 1'b0;
        offer(1'b1, 32'h00500093, 32'h400);
        tick();
        chk("rf_ov0", OUT_VALID, 1);
        offer(1'b0, 32'h0, 32'h0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rf_ov",  OUT_VALID, 0);
        chk("rf_ir",  IN_READY,  1);
        chk("rf_pc",  OUT_PC,    0);
        chk("rf_imm", IMM,       0);
        chk("rf_rd",  RD,        0);
        chk("rf_wr",  REG_WR,    0);
        chk("rf_op2", OP2_SEL,   0);

        // RV32E register bound
        e_valid = 1'b1;
        IN_INSTR = 32'h000008B3;
        tick();
        chk("e_x17_ov",  e_out_valid, 1);
        chk("e_x17_ill", e_ill,       1);
        chk("e_x17_wr",  e_reg_wr,    0);
        chk("e_x17_mm",  e_mm,        0);
        IN_INSTR = 32'h000007B3;
        tick();
        chk("e_x15_ill", e_ill,    0);
        chk("e_x15_wr",  e_reg_wr, 1);
        e_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
